// File: rtl/dm_ram_pkg.sv
// Shared widths and word/address types for the MIPS data memory.
package dm_pkg;

  localparam int unsigned DM_DATA_W = 30;
  localparam int unsigned DM_ADDR_W = 10;

  typedef logic [DM_DATA_W-1:0] dm_word_t;
  typedef logic [DM_ADDR_W-1:0] dm_addr_t;

endpackage : dm_pkg

// File: rtl/dm_ram.sv
// Single-port data memory: one store per clock, combinational load data.
// Define DM_REG_RD_EN for a registered, read-first output with 1-cycle latency.
module dm_ram
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = DM_DATA_W,
  parameter int unsigned ADDR_W = DM_ADDR_W,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memwr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic              w_we;
  logic [DATA_W-1:0] w_rd;

  // An unknown or low memwr never commits a write; reset blocks writes too.
  assign w_we = (memwr == 1'b1) && !rst;

  // Data words carry no reset; the valid bits below give the cleared view.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[addr] <= datain;
    end
  end

  // One valid bit per word, cleared asynchronously so reset is instant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_we) begin
      r_valid[addr] <= 1'b1;
    end
  end

  assign w_rd = r_valid[addr] ? r_mem[addr] : '0;

`ifdef DM_REG_RD_EN
  logic [DATA_W-1:0] r_dout;

  // Captures the pre-write contents at each edge (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
    end else begin
      r_dout <= w_rd;
    end
  end

  assign dataout = r_dout;
`else
  assign dataout = w_rd;
`endif

endmodule : dm_ram

// File: tb/tb_dm_ram.sv
// Self-checking bench for dm_ram (combinational-read build).
module tb_dm_ram;
  import dm_pkg::*;

  logic     clk;
  logic     rst;
  logic     memwr;
  dm_addr_t addr;
  dm_word_t datain;
  dm_word_t dataout;

  int n_vec;
  int n_err;
  dm_word_t exp_q[$];

  typedef struct {
    logic     we;
    dm_addr_t a;
    dm_word_t d;
    dm_word_t pre;
    dm_word_t post;
  } vec_t;

  localparam int unsigned NVEC = 17;
  vec_t vecs[NVEC];

  dm_ram dut (
    .clk    (clk),
    .rst    (rst),
    .memwr  (memwr),
    .addr   (addr),
    .datain (datain),
    .dataout(dataout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push_exp(input dm_word_t e);
    exp_q.push_back(e);
  endtask

  task automatic check_rd(input string name);
    dm_word_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, dataout=%h", name, dataout);
    end else begin
      e = exp_q.pop_front();
      if (dataout !== e) begin
        n_err++;
        $display("FAIL %s: dataout=%h expected=%h", name, dataout, e);
      end
    end
  endtask

  task automatic drive(input logic we, input dm_addr_t a, input dm_word_t d);
    memwr  = we;
    addr   = a;
    datain = d;
  endtask

  // Combinational look at one address while clk is stable.
  task automatic peek(input dm_addr_t a, input dm_word_t e, input string name);
    addr = a;
    push_exp(e);
    #1 check_rd(name);
  endtask

  function automatic vec_t mk(input logic we, input dm_addr_t a, input dm_word_t d,
                              input dm_word_t pre, input dm_word_t post);
    vec_t v;
    v.we = we; v.a = a; v.d = d; v.pre = pre; v.post = post;
    return v;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;

    vecs[0]  = mk(1'b0, 10'h000, 30'h0000_0000, 30'h0000_0000, 30'h0000_0000);
    vecs[1]  = mk(1'b0, 10'h2AA, 30'h3FFF_FFFF, 30'h0000_0000, 30'h0000_0000);
    vecs[2]  = mk(1'b0, 10'h3FF, 30'h0000_0000, 30'h0000_0000, 30'h0000_0000);
    vecs[3]  = mk(1'b0, 10'h2AA, 30'h3FFF_FFFF, 30'h0000_0000, 30'h0000_0000);
    vecs[4]  = mk(1'b0, 10'h248, 30'h2FFF_FFFF, 30'h0000_0000, 30'h0000_0000);
    vecs[5]  = mk(1'b0, 10'h248, 30'h2FFF_FFFF, 30'h0000_0000, 30'h0000_0000);
    vecs[6]  = mk(1'b1, 10'h248, 30'h2FFF_FFFF, 30'h0000_0000, 30'h2FFF_FFFF);
    vecs[7]  = mk(1'b0, 10'h248, 30'h0000_0000, 30'h2FFF_FFFF, 30'h2FFF_FFFF);
    vecs[8]  = mk(1'b0, 10'h2AA, 30'h0000_0000, 30'h0000_0000, 30'h0000_0000);
    vecs[9]  = mk(1'b1, 10'h000, 30'h0000_0001, 30'h0000_0000, 30'h0000_0001);
    vecs[10] = mk(1'b1, 10'h3FF, 30'h3FFF_FFFF, 30'h0000_0000, 30'h3FFF_FFFF);
    vecs[11] = mk(1'b0, 10'h001, 30'h0000_0000, 30'h0000_0000, 30'h0000_0000);
    vecs[12] = mk(1'b0, 10'h3FE, 30'h0000_0000, 30'h0000_0000, 30'h0000_0000);
    vecs[13] = mk(1'b0, 10'h000, 30'h0000_0000, 30'h0000_0001, 30'h0000_0001);
    vecs[14] = mk(1'b0, 10'h3FF, 30'h0000_0000, 30'h3FFF_FFFF, 30'h3FFF_FFFF);
    vecs[15] = mk(1'b1, 10'h248, 30'h1555_5555, 30'h2FFF_FFFF, 30'h1555_5555);
    vecs[16] = mk(1'b0, 10'h248, 30'h0000_0000, 30'h1555_5555, 30'h1555_5555);

    rst = 1'b1;
    drive(1'b0, 10'h000, 30'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    peek(10'h3FF, 30'h0, "in_reset");
    rst = 1'b0;

    // Table: read before the edge (old data), then after it (new data).
    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].a, vecs[i].d);
      push_exp(vecs[i].pre);
      #1 check_rd($sformatf("vec%0d_pre", i));
      push_exp(vecs[i].post);
      @(posedge clk);
      #1 check_rd($sformatf("vec%0d_post", i));
    end

    // Inputs changed between edges: only the values present at the edge count.
    @(negedge clk);
    drive(1'b1, 10'h2AA, 30'h3FFF_FFFF);
    #2 drive(1'b1, 10'h248, 30'h2FFF_FFFF);
    @(posedge clk);
    #1 memwr = 1'b0;
    peek(10'h248, 30'h2FFF_FFFF, "midcyc_248");
    peek(10'h2AA, 30'h0, "midcyc_2aa");

    // Unknown write enable must not write.
    @(negedge clk);
    drive(1'bx, 10'h001, 30'h0001_2345);
    @(posedge clk);
    #1 memwr = 1'b0;
    peek(10'h001, 30'h0, "memwr_x");

    // Async reset between edges clears everything with no clock edge.
    @(negedge clk);
    addr = 10'h248;
    #1 rst = 1'b1;
    peek(10'h248, 30'h0, "arst_248");
    peek(10'h000, 30'h0, "arst_000");
    peek(10'h3FF, 30'h0, "arst_3ff");

    // A write edge while reset is held is ignored.
    drive(1'b1, 10'h3FF, 30'h3FFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    memwr = 1'b0;
    peek(10'h3FF, 30'h0, "wr_in_reset");
    peek(10'h2AA, 30'h0, "post_rst_2aa");

    // Memory works normally again after reset.
    @(negedge clk);
    drive(1'b1, 10'h3FF, 30'h00AB_CDEF);
    @(posedge clk);
    #1 memwr = 1'b0;
    peek(10'h3FF, 30'h00AB_CDEF, "post_rst_wr");
    peek(10'h3FE, 30'h0, "post_rst_nbr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dm_ram
